keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Scans an external 4x4 matrix keypad through breakout GPIO pins and debounces the key matrix.
- Produces the 16-bit keypad bitmap that feeds the z23 core's keypad_input port; today that port is tied to zero.
- Sits upstream of the core, inside the Geriatrics wrapper, on otherwise-unused GPIO.
- Also emits a one-cycle change event and a lowest-pressed-key code for polling or interrupt use.

Parameters:
- SCAN_DIV, 16: clock cycles each column is driven. Minimum 4, which covers the 2-flop sync delay plus settle.
- DEBOUNCE_SCANS, 3: number of consecutive identical full scans required before the bitmap is accepted. Minimum 1.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- en  input  1  scan enable; low = idle
- row_n  input  4  keypad rows; active-low, externally pulled up; asynchronous to clk
- col_n  output  4  column drive; active-low, one column low at a time
- keypad_input  output  16  debounced pressed bitmap; bit = col*4 + row
- key_event  output  1  one-cycle pulse when keypad_input changes
- key_any  output  1  OR of keypad_input
- key_code  output  4  index of lowest set bit of keypad_input; 0 when none set

Behaviour:
- Clock and reset: one clock (clk); reset nrst is asynchronous and active-low.
- Reset values: col_n=4'b1111, keypad_input=0, key_event=0, key_any=0, key_code=0. All counters, the snapshot and the previous snapshot clear to 0. FSM enters IDLE.
- row_n passes through a 2-flop synchronizer (sync2) before use. Synchronizer flops reset to 4'b1111.
- FSM states: IDLE, SCAN, COMPARE.
- IDLE:
  - col_n=1111; div_cnt, col_idx and stable_cnt held at 0.
  - en=1 moves to SCAN on the next cycle.
- SCAN:
  - col_n = ~(1<<col_idx); div_cnt counts 0..SCAN_DIV-1.
  - When div_cnt==SCAN_DIV-1, snap[col_idx*4 +: 4] <= ~row_sync, div_cnt wraps to 0, and col_idx increments.
  - When col_idx==3 is sampled, col_idx wraps to 0 and the FSM goes to COMPARE.
- COMPARE (one cycle, col_n=1111):
  - If snap==prev_snap: stable_cnt saturates at DEBOUNCE_SCANS-1. Otherwise stable_cnt=0 and prev_snap<=snap.
  - Acceptance condition: the post-update stable_cnt == DEBOUNCE_SCANS-1.
  - On acceptance, if snap != keypad_input: keypad_input<=snap and key_event=1 in the following cycle. Otherwise no event.
  - DEBOUNCE_SCANS=1 accepts every scan.
  - The FSM then returns to SCAN (en=1) or IDLE (en=0).
- Scan period: 4*SCAN_DIV+1 cycles.
- First acceptance latency: DEBOUNCE_SCANS scans after a stable input; the bitmap updates on the COMPARE cycle of the last scan.
- key_any and key_code are registered and update in the same cycle as keypad_input.
- key_event is high for exactly one cycle per change, never two in a row.
- en deasserted mid-scan: the next cycle goes to IDLE with col_n=1111. The partial snap is discarded and stable_cnt is cleared. keypad_input holds its last value and no event is produced. Re-enable restarts at column 0.
- A stable key release is handled the same way as a press: the bit clears and key_event pulses.
- Simultaneous multiple keys: all bits are reported. No ghost filtering.
- nrst asserted mid-operation: all state returns to reset values immediately. No event on release.

Decomposition:
- Package keypad_pkg holds:
  - typedef enum logic [1:0] {IDLE, SCAN, COMPARE} kp_state_t
  - localparams NUM_COLS=4, NUM_ROWS=4, KEY_W=16
- Sub-module sync2: parameterised-width 2-flop synchronizer with async active-low reset and reset value as a parameter.
- FSM, counters and debounce stay in keypad_scanner.

Test Plan:
- Reset and idle:
  - Assert nrst=0 mid-scan -> col_n=1111 and keypad_input=0 asynchronously.
  - With en=0 and row_n=0000 for 200 cycles -> col_n stays 1111, no key_event.
- Single press (SCAN_DIV=4, DEBOUNCE_SCANS=3, 17-cycle scan):
  - Row1 is pulled low only while col 2 is driven, from before the first scan.
  - -> keypad_input=16'h0200, key_code=9, key_any=1, and one key_event at the end of scan 3.
- Bounce:
  - Toggle the key-9 contact every scan for 5 scans, then hold it.
  - -> no key_event during toggling; acceptance exactly 3 scans after hold begins.
- Release:
  - From keypad_input=16'h0200, release the key.
  - -> keypad_input=0, key_code=0, key_any=0, one key_event after 3 clean scans.
- Multi-key and boundary:
  - Press keys 0 and 15 together -> keypad_input=16'h8001, key_code=0.
  - With DEBOUNCE_SCANS=1, every changed scan produces an event.
- Enable abort:
  - Drop en during column 2 of a confirming scan.
  - -> no update, col_n=1111 the next cycle.
  - Re-enable -> a full 3-scan debounce is required again.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 matrix keypad scanner.
//   kp_state_t  : scanner FSM states
//   NUM_COLS/NUM_ROWS/KEY_W : matrix geometry and bitmap width
//   lowest_key(): index of lowest set bit of a key bitmap, 0 when empty
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, COMPARE} kp_state_t;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int KEY_W    = 16;

  function automatic logic [3:0] lowest_key(input logic [KEY_W-1:0] bm);
    logic [3:0] code;
    code = 4'd0;
    // Walk downward so the last hit is the lowest index
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (bm[i]) code = 4'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// sync2: parameterised-width two-flop synchronizer for asynchronous inputs.
//   clk    : destination clock
//   nrst   : asynchronous active-low reset, flops load RST_VAL
//   i_d    : asynchronous input bus
//   o_q    : synchronized output bus (two clk cycles of latency)
module sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces whole-matrix snapshots and publishes a stable pressed bitmap.
//   clk          : system clock
//   nrst         : asynchronous active-low reset
//   en           : scan enable, low keeps the scanner idle
//   row_n[3:0]   : keypad rows, active-low, asynchronous to clk
//   col_n[3:0]   : column drive, active-low, at most one column low
//   keypad_input : debounced pressed bitmap, bit = col*4 + row
//   key_event    : one-cycle pulse whenever keypad_input changes
//   key_any      : OR of keypad_input
//   key_code     : index of lowest pressed key, 0 when none
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [KEY_W-1:0]    keypad_input,
  output logic                key_event,
  output logic                key_any,
  output logic [3:0]          key_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX    = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

  kp_state_t             r_state;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [1:0]            r_col_idx;
  logic [CNT_W-1:0]      r_stable_cnt;
  logic [KEY_W-1:0]      r_snap;
  logic [KEY_W-1:0]      r_prev_snap;
  logic                  r_prev_vld;
  logic [NUM_COLS-1:0]   r_col_n;
  logic [KEY_W-1:0]      r_keypad;
  logic                  r_event;
  logic                  r_any;
  logic [3:0]            r_code;

  logic [NUM_ROWS-1:0]   w_row_sync;
  logic                  w_match;
  logic [CNT_W-1:0]      w_stable_nxt;
  logic                  w_accept;

  sync2 #(.WIDTH(NUM_ROWS), .RST_VAL({NUM_ROWS{1'b1}})) u_row_sync (
    .clk  (clk),
    .nrst (nrst),
    .i_d  (row_n),
    .o_q  (w_row_sync)
  );

  // prev_vld distinguishes "no reference scan yet" from a genuine match, so
  // every restart needs the full number of identical scans before acceptance.
  always_comb begin
    w_match      = r_prev_vld && (r_snap == r_prev_snap);
    w_stable_nxt = '0;
    if (w_match) begin
      w_stable_nxt = (r_stable_cnt == STABLE_MAX) ? STABLE_MAX : r_stable_cnt + 1'b1;
    end
    w_accept = (w_stable_nxt == STABLE_MAX);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_div_cnt    <= '0;
      r_col_idx    <= 2'd0;
      r_stable_cnt <= '0;
      r_snap       <= '0;
      r_prev_snap  <= '0;
      r_prev_vld   <= 1'b0;
      r_col_n      <= 4'b1111;
      r_keypad     <= '0;
      r_event      <= 1'b0;
      r_any        <= 1'b0;
      r_code       <= 4'd0;
    end else begin
      r_event <= 1'b0;
      case (r_state)
        IDLE: begin
          r_col_n      <= 4'b1111;
          r_div_cnt    <= '0;
          r_col_idx    <= 2'd0;
          r_stable_cnt <= '0;
          r_prev_vld   <= 1'b0;
          if (en) begin
            r_state <= SCAN;
            r_col_n <= 4'b1110;
          end
        end
        SCAN: begin
          if (!en) begin
            // Abort: drop the partial snapshot and restart debounce later
            r_state      <= IDLE;
            r_col_n      <= 4'b1111;
            r_div_cnt    <= '0;
            r_col_idx    <= 2'd0;
            r_stable_cnt <= '0;
            r_prev_vld   <= 1'b0;
            r_snap       <= '0;
          end else if (r_div_cnt == DIV_MAX) begin
            r_snap[r_col_idx*NUM_ROWS +: NUM_ROWS] <= ~w_row_sync;
            r_div_cnt <= '0;
            if (r_col_idx == 2'd3) begin
              r_col_idx <= 2'd0;
              r_col_n   <= 4'b1111;
              r_state   <= COMPARE;
            end else begin
              r_col_idx <= r_col_idx + 2'd1;
              r_col_n   <= ~(4'b0001 << (r_col_idx + 2'd1));
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        COMPARE: begin
          r_stable_cnt <= w_stable_nxt;
          r_prev_vld   <= 1'b1;
          if (!w_match) r_prev_snap <= r_snap;
          if (w_accept && (r_snap != r_keypad)) begin
            r_keypad <= r_snap;
            r_any    <= |r_snap;
            r_code   <= lowest_key(r_snap);
            r_event  <= 1'b1;
          end
          if (en) begin
            r_state <= SCAN;
            r_col_n <= 4'b1110;
          end else begin
            r_state <= IDLE;
            r_col_n <= 4'b1111;
          end
        end
        default: begin
          r_state <= IDLE;
          r_col_n <= 4'b1111;
        end
      endcase
    end
  end

  assign col_n        = r_col_n;
  assign keypad_input = r_keypad;
  assign key_event    = r_event;
  assign key_any      = r_any;
  assign key_code     = r_code;

endmodule
